// File: rtl/lcd_hex_writer.sv
// HD44780-style LCD writer: one-time init, then per request an address command and DIGITS hex characters.
// Each byte occupies a timed slot with an EN pulse inside it; start is honoured only while ready=1.
module lcd_hex_writer #(
  parameter int DIGITS  = 4,
  parameter int T_PWRUP = 750000,
  parameter int T_CHAR  = 2500,
  parameter int T_CLEAR = 100000,
  parameter int EN_RISE = 20,
  parameter int EN_FALL = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  line,
  input  logic [3:0]            col,
  input  logic                  blank_lz,
  input  logic                  clear_req,
  output logic [7:0]            LCD_DATA,
  output logic                  LCD_RS,
  output logic                  LCD_EN,
  output logic                  LCD_RW,
  output logic                  LCD_ON,
  output logic                  LCD_BLON,
  output logic                  ready,
  output logic                  done
);

  localparam int TMAX0 = (T_PWRUP > T_CLEAR) ? T_PWRUP : T_CLEAR;
  localparam int TMAX  = (TMAX0 > T_CHAR) ? TMAX0 : T_CHAR;
  localparam int CW    = $clog2(TMAX + 1);

  localparam logic [CW-1:0] PWR_LAST = CW'(T_PWRUP - 1);
  localparam logic [CW-1:0] CHR_LAST = CW'(T_CHAR - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(T_CLEAR - 1);
  localparam logic [CW-1:0] RISE     = CW'(EN_RISE);
  localparam logic [CW-1:0] FALL     = CW'(EN_FALL);
  localparam logic [3:0]    LAST_IDX = 4'(DIGITS - 1);

  typedef enum logic [3:0] {
    S_PWRUP, S_FUNC, S_DISP, S_CLR, S_ENTRY,
    S_IDLE, S_OPT_CLR, S_ADDR, S_CHAR, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                en_q, en_d;
  logic [4*DIGITS-1:0] shreg_q, shreg_d;
  logic [3:0]          idx_q, idx_d;
  logic                nz_q, nz_d;
  logic                line_q, line_d;
  logic [3:0]          col_q, col_d;
  logic                blank_q, blank_d;

  logic [3:0]    nib;
  logic          last_digit;
  logic [7:0]    char_byte;
  logic [7:0]    bus_byte;
  logic          rs_bit;
  logic          timed;
  logic [CW-1:0] slot_last;
  logic          slot_end;

  function automatic logic is_send(input state_t s);
    return (s == S_FUNC) || (s == S_DISP) || (s == S_CLR) || (s == S_ENTRY) ||
           (s == S_OPT_CLR) || (s == S_ADDR) || (s == S_CHAR);
  endfunction

  // Byte on the bus depends only on registered state, so it is stable for a whole slot.
  always_comb begin
    nib        = shreg_q[4*DIGITS-1 -: 4];
    last_digit = (idx_q == LAST_IDX);
    if (blank_q && !nz_q && (nib == 4'h0) && !last_digit)
      char_byte = 8'h20;
    else if (nib < 4'd10)
      char_byte = 8'h30 + {4'h0, nib};
    else
      char_byte = 8'h37 + {4'h0, nib};

    bus_byte  = 8'h00;
    rs_bit    = 1'b0;
    slot_last = CHR_LAST;
    case (state_q)
      S_PWRUP:   slot_last = PWR_LAST;
      S_FUNC:    bus_byte  = 8'h38;
      S_DISP:    bus_byte  = 8'h0C;
      S_CLR:     begin bus_byte = 8'h01; slot_last = CLR_LAST; end
      S_ENTRY:   bus_byte  = 8'h06;
      S_OPT_CLR: begin bus_byte = 8'h01; slot_last = CLR_LAST; end
      S_ADDR:    bus_byte  = {1'b1, line_q, 2'b00, col_q};
      S_CHAR:    begin bus_byte = char_byte; rs_bit = 1'b1; end
      default:   ;
    endcase
    timed    = (state_q == S_PWRUP) || is_send(state_q);
    slot_end = timed && (cnt_q == slot_last);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    nz_d    = nz_q;
    line_d  = line_q;
    col_d   = col_q;
    blank_d = blank_q;

    if (timed && !slot_end)
      cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_PWRUP:   if (slot_end) state_d = S_FUNC;
      S_FUNC:    if (slot_end) state_d = S_DISP;
      S_DISP:    if (slot_end) state_d = S_CLR;
      S_CLR:     if (slot_end) state_d = S_ENTRY;
      S_ENTRY:   if (slot_end) state_d = S_IDLE;
      S_IDLE: begin
        if (start) begin
          shreg_d = data_in;
          line_d  = line;
          col_d   = col;
          blank_d = blank_lz;
          idx_d   = 4'd0;
          nz_d    = 1'b0;
          state_d = clear_req ? S_OPT_CLR : S_ADDR;
        end
      end
      S_OPT_CLR: if (slot_end) state_d = S_ADDR;
      S_ADDR:    if (slot_end) state_d = S_CHAR;
      S_CHAR: begin
        if (slot_end) begin
          shreg_d = shreg_q << 4;
          idx_d   = idx_q + 4'd1;
          nz_d    = nz_q | (nib != 4'h0);
          if (last_digit) state_d = S_DONE;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_PWRUP;
    endcase

    // EN is registered from the next counter value so it lines up with cnt_q and cannot glitch.
    en_d = is_send(state_d) && (cnt_d >= RISE) && (cnt_d < FALL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      shreg_q <= '0;
      idx_q   <= 4'd0;
      nz_q    <= 1'b0;
      line_q  <= 1'b0;
      col_q   <= 4'd0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      nz_q    <= nz_d;
      line_q  <= line_d;
      col_q   <= col_d;
      blank_q <= blank_d;
    end
  end

  assign LCD_DATA = bus_byte;
  assign LCD_RS   = rs_bit;
  assign LCD_EN   = en_q;
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;
  assign ready    = (state_q == S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Bench for lcd_hex_writer: a 4-digit and an 8-digit instance, used one at a time behind a mux,
// with expected bytes queued by the stimulus and checked by a monitor at every EN falling edge.
module tb_lcd_hex_writer;
  localparam int TP = 50, TC = 40, TCL = 80, ER = 2, EF = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, rst8, sel;
  logic        start, line, blank_lz, clear_req;
  logic [3:0]  col;
  logic [15:0] d4;
  logic [31:0] d8;

  logic [7:0] dat4, dat8;
  logic rs4, en4, rw4, on4, bl4, rdy4, dn4;
  logic rs8, en8, rw8, on8, bl8, rdy8, dn8;

  lcd_hex_writer #(.DIGITS(4), .T_PWRUP(TP), .T_CHAR(TC), .T_CLEAR(TCL), .EN_RISE(ER), .EN_FALL(EF)) u4 (
    .clk(clk), .reset(rst4), .start(start), .data_in(d4), .line(line), .col(col),
    .blank_lz(blank_lz), .clear_req(clear_req), .LCD_DATA(dat4), .LCD_RS(rs4), .LCD_EN(en4),
    .LCD_RW(rw4), .LCD_ON(on4), .LCD_BLON(bl4), .ready(rdy4), .done(dn4));

  lcd_hex_writer #(.DIGITS(8), .T_PWRUP(TP), .T_CHAR(TC), .T_CLEAR(TCL), .EN_RISE(ER), .EN_FALL(EF)) u8 (
    .clk(clk), .reset(rst8), .start(start), .data_in(d8), .line(line), .col(col),
    .blank_lz(blank_lz), .clear_req(clear_req), .LCD_DATA(dat8), .LCD_RS(rs8), .LCD_EN(en8),
    .LCD_RW(rw8), .LCD_ON(on8), .LCD_BLON(bl8), .ready(rdy8), .done(dn8));

  logic [7:0] dat_m;
  logic rs_m, en_m, rdy_m, dn_m, rst_m;
  assign dat_m = sel ? dat8 : dat4;
  assign rs_m  = sel ? rs8  : rs4;
  assign en_m  = sel ? en8  : en4;
  assign rdy_m = sel ? rdy8 : rdy4;
  assign dn_m  = sel ? dn8  : dn4;
  assign rst_m = sel ? rst8 : rst4;

  typedef struct {
    logic       rs;
    logic [7:0] dat;
    int         gap;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0, done_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic push(input logic rs, input logic [7:0] dat, input int gap);
    exp_t e;
    e.rs = rs; e.dat = dat; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38, 0);
    push(1'b0, 8'h0C, TC);
    push(1'b0, 8'h01, TC);
    push(1'b0, 8'h06, TCL);
  endtask

  // Monitor: every EN falling edge outside reset is one byte; check value, RS, slot spacing, EN width.
  int  cyc = 0, last_fall = 0, en_hi = 0;
  logic en_prev = 1'b0, dn_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_m) begin
      en_hi   = 0;
      en_prev = 1'b0;
    end else begin
      if (en_m) en_hi++;
      if (en_prev && !en_m) begin
        if (q.size() == 0) begin
          timeout("unexpected_byte");
          $display("  stray byte 0x%0h rs=%0d", dat_m, rs_m);
        end else begin
          e = q.pop_front();
          chk("byte", {23'd0, rs_m, dat_m}, {23'd0, e.rs, e.dat});
          if (e.gap != 0) chk("slot_gap", cyc - last_fall, e.gap);
          chk("en_width", en_hi, EF - ER);
        end
        last_fall = cyc;
        en_hi     = 0;
      end
      en_prev = en_m;
    end
    if (dn_prev) chk("ready_after_done", int'(rdy_m), 1);
    if (dn_m) begin
      done_cnt++;
      chk("queue_drained_at_done", q.size(), 0);
    end
    dn_prev = dn_m;
  end

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!rdy_m && n < budget) begin @(negedge clk); n++; end
    if (!rdy_m) timeout("wait_ready");
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!dn_m && n < budget) begin @(negedge clk); n++; end
    if (!dn_m) timeout("wait_done");
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("ready_low_after_start", int'(rdy_m), 0);
  endtask

  task automatic setup(input logic ln, input logic [3:0] c, input logic bz, input logic cr);
    line = ln; col = c; blank_lz = bz; clear_req = cr;
  endtask

  initial begin
    int n;
    sel = 1'b0; rst4 = 1'b1; rst8 = 1'b1; start = 1'b0;
    d4 = 16'h0; d8 = 32'h0;
    setup(1'b0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    chk("rst_data", int'(dat_m), 0);
    chk("rst_rs", int'(rs_m), 0);
    chk("rst_en", int'(en_m), 0);
    chk("rst_ready", int'(rdy_m), 0);
    chk("rst_done", int'(dn_m), 0);
    chk("tie_rw", int'(rw4), 0);
    chk("tie_on", int'(on4), 1);
    chk("tie_blon", int'(bl4), 1);

    // Init sequence with stray start pulses that must be ignored.
    push_init();
    d4 = 16'h1234;
    rst4 = 1'b0;
    n = 0;
    while (!rdy_m && n < 400) begin
      @(negedge clk);
      n++;
      start = (n == 30 || n == 200);
    end
    start = 1'b0;
    chk("init_ready_window", int'(n >= 250 && n <= 260), 1);

    // 0x1A3F on row 1 col 2; data and start disturbed mid-request, start also in the done cycle.
    d4 = 16'h1A3F; setup(1'b1, 4'd2, 1'b0, 1'b0);
    push(1'b0, 8'hC2, 0);
    push(1'b1, 8'h31, TC); push(1'b1, 8'h41, TC); push(1'b1, 8'h33, TC); push(1'b1, 8'h46, TC);
    do_start();
    repeat (60) @(negedge clk);
    d4 = 16'hFFFF; line = 1'b0; clear_req = 1'b1;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(2000);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    chk("done_count_a", done_cnt, 1);

    // Leading blanks with optional clear.
    d4 = 16'h0050; setup(1'b0, 4'd0, 1'b1, 1'b1);
    push(1'b0, 8'h01, 0); push(1'b0, 8'h80, TCL);
    push(1'b1, 8'h20, TC); push(1'b1, 8'h20, TC); push(1'b1, 8'h35, TC); push(1'b1, 8'h30, TC);
    do_start();
    wait_done(2000);
    wait_ready(10);

    d4 = 16'h0000; setup(1'b0, 4'd0, 1'b1, 1'b0);
    push(1'b0, 8'h80, 0);
    push(1'b1, 8'h20, TC); push(1'b1, 8'h20, TC); push(1'b1, 8'h20, TC); push(1'b1, 8'h30, TC);
    do_start();
    wait_done(2000);
    wait_ready(10);

    d4 = 16'h0A00; setup(1'b1, 4'd15, 1'b1, 1'b0);
    push(1'b0, 8'hCF, 0);
    push(1'b1, 8'h20, TC); push(1'b1, 8'h41, TC); push(1'b1, 8'h30, TC); push(1'b1, 8'h30, TC);
    do_start();
    wait_done(2000);
    wait_ready(10);
    chk("done_count_b", done_cnt, 4);

    // Reset while the third character has EN high.
    d4 = 16'h1234; setup(1'b0, 4'd5, 1'b0, 1'b0);
    push(1'b0, 8'h85, 0); push(1'b1, 8'h31, TC); push(1'b1, 8'h32, TC);
    do_start();
    n = 0;
    while (q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (q.size() != 0) timeout("wait_two_chars");
    n = 0;
    while (!en_m && n < 200) begin @(negedge clk); n++; end
    if (!en_m) timeout("wait_third_en");
    rst4 = 1'b1;
    @(negedge clk);
    chk("en_drop_on_reset", int'(en_m), 0);
    chk("ready_low_in_reset", int'(rdy_m), 0);
    push_init();
    @(negedge clk) rst4 = 1'b0;
    wait_ready(400);
    repeat (20) @(negedge clk);
    chk("no_done_after_abort", done_cnt, 4);

    // Eight-digit instance.
    rst4 = 1'b1;
    @(negedge clk) sel = 1'b1;
    push_init();
    @(negedge clk) rst8 = 1'b0;
    wait_ready(400);
    d8 = 32'hFFFF_FFFF; setup(1'b0, 4'd0, 1'b0, 1'b0);
    push(1'b0, 8'h80, 0);
    for (int i = 0; i < 8; i++) push(1'b1, 8'h46, TC);
    do_start();
    wait_done(3000);
    wait_ready(10);
    repeat (50) @(negedge clk);

    chk("final_queue_empty", q.size(), 0);
    chk("final_done_count", done_cnt, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_hex_writer.md
LCD_HEX_WRITER -- requirements
Module: lcd_hex_writer

Interface
REQ-001 The block SHALL provide parameter DIGITS, default 4, giving the number of hex digits written per request (legal range 1..8).
REQ-002 The block SHALL provide parameter T_PWRUP, default 750000, giving the power-up wait in clk cycles (15 ms at 50 MHz).
REQ-003 The block SHALL provide parameter T_CHAR, default 2500, giving the per-command/per-character slot in clk cycles.
REQ-004 The block SHALL provide parameter T_CLEAR, default 100000, giving the slot for the clear command in clk cycles.
REQ-005 The block SHALL provide parameters EN_RISE, default 20, and EN_FALL, default 1000, giving the LCD_EN high window as slot-counter values.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 The block SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous active-high reset
- start  in  1  write request, sampled only when ready=1
- data_in  in  4*DIGITS  value to display, MSB nibble first
- line  in  1  target row (0=top, 1=bottom)
- col  in  4  starting column 0..15
- blank_lz  in  1  1 = leading zeros written as space (0x20)
- clear_req  in  1  1 = issue clear (0x01) before the address command
- LCD_DATA  out  8  data bus
- LCD_RS  out  1  0 = command, 1 = character
- LCD_EN  out  1  enable strobe
- LCD_RW  out  1  tied 0
- LCD_ON  out  1  tied 1
- LCD_BLON  out  1  tied 1
- ready  out  1  1 = idle, start accepted
- done  out  1  one-cycle pulse when a request completes

Function
REQ-008 After reset the FSM SHALL run states PWRUP (T_PWRUP wait, EN low) -> FUNC 0x38 -> DISP 0x0C -> CLR 0x01 -> ENTRY 0x06 -> IDLE, once only; a later start SHALL NOT re-run initialisation.
REQ-009 Every command/character SHALL use a WAIT slot: bus and RS held stable for the whole slot, LCD_EN=1 for counter in [EN_RISE, EN_FALL), slot length T_CHAR, or T_CLEAR for 0x01.
REQ-010 In IDLE with ready=1, start=1 SHALL latch data_in, line, col, blank_lz and clear_req, drive ready=0 on the next cycle, and go to OPT_CLR if clear_req=1, else ADDR.
REQ-011 OPT_CLR SHALL send 0x01 (RS=0, T_CLEAR slot), then go to ADDR.
REQ-012 ADDR SHALL send command 0x80 | (line<<6) | col (RS=0).
REQ-013 CHAR SHALL send DIGITS characters (RS=1), most-significant nibble first, nibble 0-9 -> 0x30+n, A-F -> 0x37+n.
REQ-014 With blank_lz=1, each zero nibble preceding the first non-zero nibble SHALL be written as 0x20; the least-significant digit SHALL always be written as a numeral.
REQ-015 Column overflow SHALL NOT be checked; characters past column 15 follow LCD auto-increment.
REQ-016 After the last character slot the FSM SHALL pulse done=1 for exactly one cycle, then raise ready=1 the following cycle in IDLE.
REQ-017 start while ready=0, including during init, SHALL be ignored and not queued; inputs changing mid-request SHALL NOT affect the transfer in progress.
REQ-018 A simultaneous start and done cycle SHALL ignore start, because ready=0 in that cycle.
REQ-019 The slot counter SHALL be wide enough for max(T_PWRUP, T_CLEAR) and SHALL clear to 0 at every slot end.

Reset
REQ-020 Reset SHALL drive LCD_DATA=0x00, LCD_RS=0, LCD_EN=0, ready=0, done=0, counter=0 and state=PWRUP on the next clk edge.
REQ-021 Reset asserted mid-operation (any state, including EN high) SHALL abort the operation, drop EN that cycle, and restart the full init sequence.

Verification (bench uses T_PWRUP=50, T_CHAR=40, T_CLEAR=80, EN_RISE=2, EN_FALL=20)
REQ-022 Release reset -> command bytes 0x38, 0x0C, 0x01, 0x06 on EN falling edges with RS=0, ready rises after 50+40+40+80+40 cycles (plus state overhead), exactly one EN pulse per byte.
REQ-023 DIGITS=4, data_in=0x1A3F, line=1, col=2, clear_req=0 -> 0xC2 (RS=0), then 0x31, 0x41, 0x33, 0x46 (RS=1), single done pulse, ready=1 next cycle.
REQ-024 data_in=0x0050, blank_lz=1, clear_req=1 -> 0x01 with an 80-cycle slot, 0x80, then 0x20, 0x20, 0x35, 0x30; data_in=0x0000 -> 0x20, 0x20, 0x20, 0x30.
REQ-025 start pulses during init and mid-request, plus data_in changed mid-request -> no extra bytes, original latched value displayed.
REQ-026 Reset asserted during the third character with EN high -> EN=0 next cycle, full init re-runs, no done pulse.
REQ-027 DIGITS=8, data_in=0xFFFFFFFF -> eight 0x46 characters after the address byte, done once.
